nrd_divider_param: RTL and testbench

- Parametrised non-restoring sequential divider.
- Divides a 2N-bit dividend by an N-bit divisor and returns an N-bit quotient and an N-bit remainder.
- Next-generation replacement for the fixed 10/5-bit divider in the arithmetic datapath.
- Adds width generality, a start/busy/done handshake, registered error flags and optional signed operation.

---
 rtl/nrd_pkg.sv | 6 +
 rtl/nrd_addsub_step.sv | 15 +
 rtl/nrd_divider_param.sv | 110 +++++++++++
 tb/tb_nrd_divider_param.sv | 139 +++++++++++++
 4 files changed

// File: rtl/nrd_pkg.sv
// nrd_pkg: shared state encoding and counter sizing for nrd_divider_param
package nrd_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, ITER, CORRECT, DONE} state_t;
  localparam int N_MAX = 32;
  localparam int CNT_W = $clog2(N_MAX + 1);
endpackage

// File: rtl/nrd_addsub_step.sv
// nrd_addsub_step: one non-restoring shift-and-add/subtract step on the (N+1)-bit partial remainder
module nrd_addsub_step #(parameter int N = 5) (
  input  logic [N:0]   a,
  input  logic         q_msb,
  input  logic [N-1:0] d,
  output logic [N:0]   a_next,
  output logic         q_bit
);
  logic [N:0] sh;
  always_comb begin
    sh = {a[N-1:0], q_msb};
    a_next = a[N] ? sh + {1'b0, d} : sh - {1'b0, d};
    q_bit = ~a_next[N];
  end
endmodule

// File: rtl/nrd_divider_param.sv
// nrd_divider_param: 2N/N non-restoring sequential divider with start/busy/done handshake; NRD_SIGNED_EN adds signed_mode
module nrd_divider_param
  import nrd_pkg::*;
#(parameter int N = 5) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
`ifdef NRD_SIGNED_EN
  input  logic           signed_mode,
`endif
  input  logic [2*N-1:0] Dividend,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic           OV,
  output logic           DivByZero
);
  state_t state;
  logic [N:0] a, a_next;
  logic [N-1:0] qr, d, d_mag, r_mag, q_fin, r_fin;
  logic [2*N-1:0] dvd, dvd_mag;
  logic [CNT_W-1:0] cnt;
  logic q_bit, err, sm, sq, sr, sm_in, q_ovf;
`ifdef NRD_SIGNED_EN
  assign sm_in = signed_mode;
`else
  assign sm_in = 1'b0;
`endif
  nrd_addsub_step #(.N(N)) u_step (
    .a(a), .q_msb(qr[N-1]), .d(d), .a_next(a_next), .q_bit(q_bit)
  );
  always_comb begin
    dvd = {a[N-1:0], qr};
    dvd_mag = (sm && dvd[2*N-1]) ? -dvd : dvd;
    d_mag = (sm && d[N-1]) ? -d : d;
    r_mag = a[N] ? a[N-1:0] + d : a[N-1:0];
    q_fin = sq ? -qr : qr;
    r_fin = sr ? -r_mag : r_mag;
    q_ovf = sm && qr[N-1] && (!sq || (|qr[N-2:0]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Q <= '0;
      R <= '0;
      ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      OV <= 1'b0;
      DivByZero <= 1'b0;
      err <= 1'b0;
      sm <= 1'b0;
      sq <= 1'b0;
      sr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a <= {1'b0, Dividend[2*N-1:N]};
          qr <= Dividend[N-1:0];
          d <= Divisor;
          sm <= sm_in;
          sq <= sm_in & (Dividend[2*N-1] ^ Divisor[N-1]);
          sr <= sm_in & Dividend[2*N-1];
          Q <= '0;
          R <= '0;
          OV <= 1'b0;
          DivByZero <= 1'b0;
          ready <= 1'b0;
          busy <= 1'b1;
          state <= CHECK;
        end
        CHECK: begin
          a <= {1'b0, dvd_mag[2*N-1:N]};
          qr <= dvd_mag[N-1:0];
          d <= d_mag;
          cnt <= CNT_W'(N);
          err <= (d == '0) || (dvd_mag[2*N-1:N] >= d_mag);
          DivByZero <= (d == '0);
          OV <= (d != '0) && (dvd_mag[2*N-1:N] >= d_mag);
          state <= ((d == '0) || (dvd_mag[2*N-1:N] >= d_mag)) ? CORRECT : ITER;
        end
        ITER: begin
          a <= a_next;
          qr <= {qr[N-2:0], q_bit};
          cnt <= cnt - CNT_W'(1);
          state <= (cnt == CNT_W'(1)) ? CORRECT : ITER;
        end
        CORRECT: begin
          if (!err && q_ovf) OV <= 1'b1;
          if (!err && !q_ovf) begin
            Q <= q_fin;
            R <= r_fin;
          end
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nrd_divider_param.sv
// tb_nrd_divider_param: directed table-driven bench for nrd_divider_param (N=5); signed vectors under NRD_SIGNED_EN
module tb_nrd_divider_param;
  logic clk = 1'b0;
  logic rst, start, signed_mode;
  logic [9:0] Dividend;
  logic [4:0] Divisor, Q, R;
  logic ready, busy, done, OV, DivByZero;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [9:0] dvd;
    logic [4:0] dvs;
    bit sm;
    int q, r, ov, dz, lat;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  nrd_divider_param #(.N(5)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef NRD_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .Dividend(Dividend), .Divisor(Divisor), .Q(Q), .R(R),
    .ready(ready), .busy(busy), .done(done), .OV(OV), .DivByZero(DivByZero)
  );
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic launch(input logic [9:0] dv, input logic [4:0] ds, input bit sm);
    @(negedge clk);
    Dividend = dv;
    Divisor = ds;
    signed_mode = sm;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string nm, input int exp_lat);
    int lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (done) break;
    end
    chk({nm, "_lat"}, done ? lat : -1, exp_lat);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_Q"}, Q, 0);
    chk({nm, "_R"}, R, 0);
    chk({nm, "_ready"}, ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_OV"}, OV, 0);
    chk({nm, "_DZ"}, DivByZero, 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    Dividend = '0;
    Divisor = '0;
    vecs.push_back('{10'd100, 5'd7, 1'b0, 14, 2, 0, 0, 7});
    vecs.push_back('{10'd37, 5'd0, 1'b0, 0, 0, 0, 1, 2});
    vecs.push_back('{10'd500, 5'd7, 1'b0, 0, 0, 1, 0, 2});
    vecs.push_back('{10'd93, 5'd3, 1'b0, 31, 0, 0, 0, 7});
    vecs.push_back('{10'd1023, 5'd31, 1'b0, 0, 0, 1, 0, 2});
    vecs.push_back('{10'd0, 5'd1, 1'b0, 0, 0, 0, 0, 7});
    vecs.push_back('{10'd223, 5'd7, 1'b0, 31, 6, 0, 0, 7});
    vecs.push_back('{10'd991, 5'd31, 1'b0, 31, 30, 0, 0, 7});
    vecs.push_back('{10'd992, 5'd31, 1'b0, 0, 0, 1, 0, 2});
    vecs.push_back('{10'd30, 5'd31, 1'b0, 0, 30, 0, 0, 7});
    vecs.push_back('{10'd0, 5'd0, 1'b0, 0, 0, 0, 1, 2});
`ifdef NRD_SIGNED_EN
    vecs.push_back('{10'd924, 5'd7, 1'b1, 18, 30, 0, 0, 7});
    vecs.push_back('{10'd100, 5'd25, 1'b1, 18, 2, 0, 0, 7});
    vecs.push_back('{10'd512, 5'd31, 1'b1, 0, 0, 1, 0, 2});
    vecs.push_back('{10'd16, 5'd1, 1'b1, 0, 0, 1, 0, 7});
    vecs.push_back('{10'd1008, 5'd1, 1'b1, 16, 0, 0, 0, 7});
    vecs.push_back('{10'd924, 5'd7, 1'b0, 0, 0, 1, 0, 2});
`endif
    repeat (2) @(posedge clk);
    #1 chk_reset("rst");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      string nm = $sformatf("v%0d", i);
      launch(vecs[i].dvd, vecs[i].dvs, vecs[i].sm);
      chk({nm, "_busy"}, busy, 1);
      wait_done(nm, vecs[i].lat);
      chk({nm, "_Q"}, Q, vecs[i].q);
      chk({nm, "_R"}, R, vecs[i].r);
      chk({nm, "_OV"}, OV, vecs[i].ov);
      chk({nm, "_DZ"}, DivByZero, vecs[i].dz);
      @(posedge clk);
      #1 chk({nm, "_ready"}, ready, 1);
      chk({nm, "_done_pulse"}, done, 0);
    end
    launch(10'd100, 5'd7, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    Dividend = 10'd93;
    Divisor = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("restart", 4);
    chk("restart_Q", Q, 14);
    chk("restart_R", R, 2);
    repeat (3) @(posedge clk);
    #1 chk("restart_ignored_busy", busy, 0);
    launch(10'd100, 5'd7, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk_reset("midrst");
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("midrst_no_done", done, 0);
    chk("midrst_idle", ready, 1);
    launch(10'd100, 5'd7, 1'b0);
    start = 1'b1;
    Dividend = 10'd93;
    Divisor = 5'd3;
    wait_done("held1", 7);
    chk("held1_Q", Q, 14);
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    chk("held2_busy", busy, 1);
    wait_done("held2", 7);
    chk("held2_Q", Q, 31);
    chk("held2_R", R, 0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
